// File: rtl/srrc_response_capture_if.sv
// Sample, control, result and readout signals of the SRRC response capture block.
// The master side drives samples, start and readout address; the slave side is the capture block.
interface srrc_response_capture_if #(
  parameter int WIDTH = 18
);
  logic signed [WIDTH-1:0] y_in;
  logic                    sample_en;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic        [WIDTH-1:0] peak_mag;
  logic        [5:0]       peak_idx;
  logic        [39:0]      energy;
  logic        [5:0]       rd_addr;
  logic signed [WIDTH-1:0] rd_data;

  modport master (
    output y_in, sample_en, start, rd_addr,
    input  busy, done, peak_mag, peak_idx, energy, rd_data
  );

  modport slave (
    input  y_in, sample_en, start, rd_addr,
    output busy, done, peak_mag, peak_idx, energy, rd_data
  );
endinterface

// File: rtl/srrc_response_capture.sv
// Captures one window of DEPTH filter output samples and reports peak magnitude,
// its index and the sum of squares; the captured window can be read back by address.
module srrc_response_capture #(
  parameter int DEPTH = 21,
  parameter int WIDTH = 18
) (
  input logic                   clk,
  input logic                   reset,
  srrc_response_capture_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t state, state_next;

  logic        [AW-1:0]    wr_idx;
  logic        [AW-1:0]    idx_now;
  logic                    clear;
  logic                    take;
  logic        [WIDTH-1:0] mag;
  logic signed [2*WIDTH-1:0] sq;
  logic        [WIDTH-1:0] peak_base;
  logic        [39:0]      energy_base;
  logic        [WIDTH-1:0] peak_mag_q;
  logic        [5:0]       peak_idx_q;
  logic        [39:0]      energy_q;
  logic signed [WIDTH-1:0] rd_data_q;
  logic        [AW-1:0]    rd_a;
  logic signed [WIDTH-1:0] mem [0:DEPTH-1];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = ARMED;
      ARMED:   if (bus.sample_en) state_next = CAPTURE;
      CAPTURE: if (bus.sample_en && wr_idx == AW'(DEPTH - 1)) state_next = DONE;
      // A sample arriving with the re-arming start already belongs to the new window.
      DONE:    if (bus.start) state_next = bus.sample_en ? CAPTURE : ARMED;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      ARMED, CAPTURE: bus.busy = 1'b1;
      DONE:           bus.done = 1'b1;
      default:        ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  assign clear = bus.start && (state == IDLE || state == DONE);
  assign take  = bus.sample_en &&
                 (state == ARMED || state == CAPTURE || (state == DONE && bus.start));

  // Two's-complement negate; the most negative code maps onto 2^(WIDTH-1) unsigned.
  assign mag = bus.y_in[WIDTH-1] ? WIDTH'(-bus.y_in) : WIDTH'(bus.y_in);
  assign sq  = bus.y_in * bus.y_in;

  assign idx_now     = clear ? '0 : wr_idx;
  assign peak_base   = clear ? '0 : peak_mag_q;
  assign energy_base = clear ? '0 : energy_q;

  // NOTE: sequential state uses non-blocking assignments; later ones in the block take precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx     <= '0;
      peak_mag_q <= '0;
      peak_idx_q <= '0;
      energy_q   <= '0;
    end else begin
      if (clear) begin
        wr_idx     <= '0;
        peak_mag_q <= '0;
        peak_idx_q <= '0;
        energy_q   <= '0;
      end
      if (take) begin
        wr_idx   <= idx_now + AW'(1);
        energy_q <= energy_base + 40'($unsigned(sq));
        // Strictly greater: ties keep the earliest index.
        if (mag > peak_base) begin
          peak_mag_q <= mag;
          peak_idx_q <= 6'(idx_now);
        end
      end
    end
  end

  // NOTE: the capture buffer has no reset; only its readout register is cleared.
  always_ff @(posedge clk) begin
    if (take) mem[idx_now] <= bus.y_in;
  end

  assign rd_a = bus.rd_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset)                         rd_data_q <= '0;
    else if (bus.rd_addr < 6'(DEPTH))  rd_data_q <= mem[rd_a];
    else                               rd_data_q <= '0;
  end

  assign bus.peak_mag = peak_mag_q;
  assign bus.peak_idx = peak_idx_q;
  assign bus.energy   = energy_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_srrc_response_capture.sv
// Directed bench for srrc_response_capture: reset, impulse window, extreme negative,
// tie handling, gapped sample_en, ignored start, out-of-range readout and mid-window reset.
module tb_srrc_response_capture;

  localparam int DEPTH = 21;
  localparam int WIDTH = 18;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  srrc_response_capture_if #(.WIDTH(WIDTH)) bus ();

  srrc_response_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int     total = 0;
  int     bad   = 0;
  longint exp_e;
  int     vb [DEPTH];
  int     vc [DEPTH];

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge that consumed the inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic en, input int y);
    bus.start     = s;
    bus.sample_en = en;
    bus.y_in      = WIDTH'(y);
  endtask

  initial begin
    drive(1'b0, 1'b0, 0);
    bus.rd_addr = '0;
    reset = 1'b1;
    step();
    step();
    check("rst_busy",     bus.busy,     0);
    check("rst_done",     bus.done,     0);
    check("rst_peak_mag", bus.peak_mag, 0);
    check("rst_peak_idx", bus.peak_idx, 0);
    check("rst_energy",   bus.energy,   0);
    check("rst_rd_data",  bus.rd_data,  0);
    reset = 1'b0;

    // Window A: impulse 131071 at index 10.
    drive(1'b1, 1'b0, 0);
    step();
    check("a_armed_busy", bus.busy, 1);
    check("a_armed_done", bus.done, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, (i == 10) ? 131071 : 0);
      step();
      if (i == DEPTH - 2) check("a_not_done_early", bus.done, 0);
    end
    drive(1'b0, 1'b0, 0);
    check("a_done",     bus.done,     1);
    check("a_busy",     bus.busy,     0);
    check("a_peak_mag", bus.peak_mag, 131071);
    check("a_peak_idx", bus.peak_idx, 10);
    check("a_energy",   bus.energy,   64'd17179607041);
    bus.rd_addr = 6'd10;
    step();
    check("a_rd10", bus.rd_data, 131071);
    bus.rd_addr = 6'd25;
    step();
    check("a_rd25_zero", bus.rd_data, 0);
    step();
    check("a_hold_done",   bus.done,   1);
    check("a_hold_energy", bus.energy, 64'd17179607041);

    // Window B: armed from DONE with a coincident sample; -131072 at index 3; start mid-capture.
    for (int i = 0; i < DEPTH; i++)
      vb[i] = (i == 0) ? -7 : (i == 3) ? -131072 : (i == 7) ? 131071 : i * 3;
    exp_e = 0;
    for (int i = 0; i < DEPTH; i++) exp_e += longint'(vb[i]) * longint'(vb[i]);
    drive(1'b1, 1'b1, vb[0]);
    step();
    check("b_busy_after_rearm", bus.busy, 1);
    for (int i = 1; i < DEPTH; i++) begin
      drive(i == 12, 1'b1, vb[i]);
      step();
    end
    drive(1'b0, 1'b0, 0);
    check("b_done",     bus.done,     1);
    check("b_peak_mag", bus.peak_mag, 131072);
    check("b_peak_idx", bus.peak_idx, 3);
    check("b_energy",   bus.energy,   exp_e);
    bus.rd_addr = 6'd0;
    step();
    check("b_rd0", bus.rd_data, -7);
    bus.rd_addr = 6'd3;
    step();
    check("b_rd3", bus.rd_data, -131072);
    bus.rd_addr = 6'd12;
    step();
    check("b_rd12", bus.rd_data, 36);

    // Window C: sample_en every other cycle, tie +5000 at 4 and -5000 at 9.
    for (int i = 0; i < DEPTH; i++)
      vc[i] = (i == 4) ? 5000 : (i == 9) ? -5000 : ((i % 2) ? -(i * 100) : i * 100);
    exp_e = 0;
    for (int i = 0; i < DEPTH; i++) exp_e += longint'(vc[i]) * longint'(vc[i]);
    drive(1'b1, 1'b0, 0);
    step();
    check("c_armed_busy", bus.busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 30000);
      step();
      drive(1'b0, 1'b1, vc[i]);
      step();
      if (i == DEPTH - 2) check("c_not_done_early", bus.done, 0);
    end
    drive(1'b0, 1'b0, 0);
    check("c_done",     bus.done,     1);
    check("c_peak_mag", bus.peak_mag, 5000);
    check("c_peak_idx", bus.peak_idx, 4);
    check("c_energy",   bus.energy,   exp_e);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = 6'(a);
      step();
      check($sformatf("c_rd%0d", a), bus.rd_data, vc[a]);
    end

    // Reset at window index 12, colliding with start and sample_en.
    drive(1'b1, 1'b0, 0);
    step();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 1000);
      step();
    end
    reset = 1'b1;
    drive(1'b1, 1'b1, 1000);
    step();
    check("r_busy",     bus.busy,     0);
    check("r_done",     bus.done,     0);
    check("r_energy",   bus.energy,   0);
    check("r_peak_mag", bus.peak_mag, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 0);
    step();
    check("r_idle_busy", bus.busy, 0);
    drive(1'b1, 1'b0, 0);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, (i % 2) ? -2 : 2);
      step();
    end
    drive(1'b0, 1'b0, 0);
    check("r2_done",     bus.done,     1);
    check("r2_peak_mag", bus.peak_mag, 2);
    check("r2_peak_idx", bus.peak_idx, 0);
    check("r2_energy",   bus.energy,   84);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
